// File: rtl/port_a_ctrl.sv
// port_a_ctrl: memory-mapped WIDTH-bit output port with set/clr/tog aliases, blink engine and optional PWM
// Ports: clk_48mhz, reset (sync, active-high); bus_valid/bus_we/bus_addr/bus_wdata request;
//        bus_ready one-cycle ack carrying bus_rdata; port_a registered pin drive.
// Build option: define PORT_A_PWM_EN to add a DUTY register at address 6 that gates port_a with a 4-bit PWM.
module port_a_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24,
    parameter logic [WIDTH-1:0] RST_VAL = 8'h00
) (
    input  logic             clk_48mhz,
    input  logic             reset,
    input  logic             bus_valid,
    input  logic             bus_we,
    input  logic [2:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic             bus_ready,
    output logic [31:0]      bus_rdata,
    output logic [WIDTH-1:0] port_a
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state;
    logic [WIDTH-1:0] data, blink_mask, wv, data_nxt, gate;
    logic [DIV_W-1:0] blink_div, div_cnt;
    logic phase, access, wr;
    logic [31:0] rdata_nxt;
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata;
`ifdef PORT_A_PWM_EN
    logic [3:0] duty, pwm_cnt;
    assign gate = {WIDTH{pwm_cnt < duty}};
`else
    assign gate = '1;
`endif
    // A request is only taken in IDLE, so a strobe still high during ACK is not re-executed
    assign access = state == IDLE && bus_valid;
    assign wr = access && bus_we;
    assign wv = bus_wdata[WIDTH-1:0];
    assign data_nxt = !wr ? data :
                      bus_addr == 3'd0 ? wv :
                      bus_addr == 3'd1 ? data | wv :
                      bus_addr == 3'd2 ? data & ~wv :
                      bus_addr == 3'd3 ? data ^ wv : data;
    always_comb begin
        rdata_nxt = '0;
        case (bus_addr)
            3'd0, 3'd1, 3'd2, 3'd3: rdata_nxt[WIDTH-1:0] = data;
            3'd4: rdata_nxt[WIDTH-1:0] = blink_mask;
            3'd5: rdata_nxt[DIV_W-1:0] = blink_div;
`ifdef PORT_A_PWM_EN
            3'd6: rdata_nxt[3:0] = duty;
`endif
            default: rdata_nxt = '0;
        endcase
    end
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state <= IDLE;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
            data <= RST_VAL;
            blink_mask <= '0;
            blink_div <= '0;
            div_cnt <= '0;
            phase <= 1'b0;
            port_a <= RST_VAL;
`ifdef PORT_A_PWM_EN
            duty <= 4'hF;
            pwm_cnt <= '0;
`endif
        end else begin
            state <= access ? ACK : IDLE;
            bus_ready <= access;
            if (access)
                bus_rdata <= rdata_nxt;
            data <= data_nxt;
            if (wr && bus_addr == 3'd4)
                blink_mask <= wv;
            if (wr && bus_addr == 3'd5)
                blink_div <= bus_wdata[DIV_W-1:0];
`ifdef PORT_A_PWM_EN
            if (wr && bus_addr == 3'd6)
                duty <= bus_wdata[3:0];
            pwm_cnt <= pwm_cnt + 4'd1;
`endif
            // A new divider restarts the period; >= keeps the counter from running past a shrunk terminal count
            if ((wr && bus_addr == 3'd5) || blink_div == '0) begin
                div_cnt <= '0;
                phase <= 1'b0;
            end else if (div_cnt >= blink_div) begin
                div_cnt <= '0;
                phase <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            port_a <= (data ^ (blink_mask & {WIDTH{phase}})) & gate;
        end
    end
endmodule

// File: tb/tb_port_a_ctrl.sv
// tb_port_a_ctrl: scoreboard bench for port_a_ctrl
module tb_port_a_ctrl;
    logic clk_48mhz = 1'b0;
    logic reset = 1'b1;
    logic bus_valid = 1'b0;
    logic bus_we = 1'b0;
    logic [2:0] bus_addr = 3'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic bus_ready;
    logic [31:0] bus_rdata;
    logic [7:0] port_a;
    int n_vec = 0;
    int n_fail = 0;
    int n_ack = 0;
    typedef struct packed {
        logic rd;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic ready_prev = 1'b0;

    port_a_ctrl dut (
        .clk_48mhz(clk_48mhz),
        .reset(reset),
        .bus_valid(bus_valid),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata),
        .port_a(port_a)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    always @(negedge clk_48mhz) begin
        if (bus_ready) begin
            n_ack++;
            n_vec++;
            if (ready_prev || sb.size() == 0) begin
                n_fail++;
                $display("FAIL ack: unexpected ready (prev=%0b pending=%0d), required one pulse per accepted request", ready_prev, sb.size());
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.rd && bus_rdata !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL rdata: got %h, required %h", bus_rdata, mon_e.val);
                end
            end
        end
        ready_prev = bus_ready;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_48mhz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic check_port(input string name, input logic [7:0] exp);
`ifdef PORT_A_PWM_EN
        check(name, 32'(port_a), port_a == 8'h00 ? 32'h0 : 32'(exp));
`else
        check(name, 32'(port_a), 32'(exp));
`endif
    endtask

    task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] wd, input logic [31:0] exp);
        int waited = 0;
        exp_t e;
        e.rd = !we;
        e.val = exp;
        sb.push_back(e);
        bus_valid = 1'b1;
        bus_we = we;
        bus_addr = a;
        bus_wdata = wd;
        do begin
            step(1);
            waited++;
        end while (!bus_ready && waited < 8);
        bus_valid = 1'b0;
        check("latency", 32'(waited), 32'd1);
        step(1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        xfer(1'b1, a, wd, 32'd0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        xfer(1'b0, a, 32'd0, exp);
    endtask

    initial begin
        int a0;
        int on;
        int bad;
        step(3);
        reset = 1'b0;
        step(1);
        check_port("reset_port", 8'h00);
        check("reset_ready", 32'(bus_ready), 32'd0);
        rd(3'd0, 32'h0);
        wr(3'd0, 32'h0000_00A5);
        check_port("data_a5", 8'hA5);
        wr(3'd1, 32'h0000_000F);
        check_port("set_0f", 8'hAF);
        wr(3'd2, 32'h0000_0081);
        check_port("clr_81", 8'h2E);
        wr(3'd3, 32'h0000_00FF);
        check_port("tog_ff", 8'hD1);
        rd(3'd1, 32'hD1);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, 32'h0);
`ifndef PORT_A_PWM_EN
        wr(3'd6, 32'h0000_0007);
        rd(3'd6, 32'h0);
`endif
        wr(3'd4, 32'hFFFF_FFF0);
        wr(3'd0, 32'h0);
        wr(3'd5, 32'hFF00_0003);
        for (int k = 0; k < 16; k++) begin
            check_port("blink", ((k / 4) % 2) != 0 ? 8'hF0 : 8'h00);
            step(1);
        end
        rd(3'd4, 32'hF0);
        rd(3'd5, 32'h3);
        wr(3'd5, 32'h0);
        for (int k = 0; k < 8; k++) begin
            check_port("blink_off", 8'h00);
            step(1);
        end
        a0 = n_ack;
        sb.push_back('{rd: 1'b0, val: 32'h0});
        bus_valid = 1'b1;
        bus_we = 1'b1;
        bus_addr = 3'd3;
        bus_wdata = 32'h1;
        step(2);
        bus_valid = 1'b0;
        step(2);
        check("held_single_ack", 32'(n_ack - a0), 32'd1);
        check_port("held_single_tog", 8'h01);
        rd(3'd3, 32'h01);
        wr(3'd0, 32'h3C);
        check_port("data_3c", 8'h3C);
        a0 = n_ack;
        reset = 1'b1;
        bus_valid = 1'b1;
        bus_we = 1'b1;
        bus_addr = 3'd0;
        bus_wdata = 32'h55;
        step(1);
        bus_valid = 1'b0;
        step(1);
        reset = 1'b0;
        step(2);
        check("reset_drop_ack", 32'(n_ack - a0), 32'd0);
        check("reset_ready_low", 32'(bus_ready), 32'd0);
        check_port("reset_mid_port", 8'h00);
        rd(3'd0, 32'h0);
        rd(3'd4, 32'h0);
        rd(3'd5, 32'h0);
`ifdef PORT_A_PWM_EN
        rd(3'd6, 32'hF);
        wr(3'd6, 32'h4);
        wr(3'd0, 32'hFF);
        on = 0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (port_a == 8'hFF) on++;
            else if (port_a != 8'h00) bad++;
            step(1);
        end
        check("pwm_duty4_on", 32'(on), 32'd4);
        check("pwm_levels", 32'(bad), 32'd0);
        wr(3'd6, 32'h0);
        step(1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (port_a != 8'h00) bad++;
            step(1);
        end
        check("pwm_duty0_off", 32'(bad), 32'd0);
`else
        wr(3'd0, 32'hFF);
        on = 0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (port_a == 8'hFF) on++;
            step(1);
        end
        check("nopwm_on", 32'(on), 32'd16);
        check("nopwm_bad", 32'(bad), 32'd0);
`endif
        step(4);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
